lifo_stack: RTL
===============

# lifo_stack

Parametrised LIFO stack: successor to the team's fixed 8-bit × 256-entry stack, generalised in data width and depth. It adds full/empty/count status, a combinational top-of-stack peek, overflow/underflow error pulses, a push+pop exchange mode and a synchronous clear. It sits between a datapath producer and consumer, such as an expression evaluator or return-address store, as a single-clock-domain buffer.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 256, number of entries (≥2; need not be a power of two)
- CW (localparam), $clog2(DEPTH+1), width of `count`
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear; empties the stack
- push  input  1  write `din` onto the stack
- pop  input  1  remove the top entry into `dout`
- din  input  WIDTH  data to push
- dout  output  WIDTH  registered value of the last popped entry
- dout_valid  output  1  one-cycle pulse: `dout` was updated by the previous edge
- top  output  WIDTH  combinational peek, mem[count-1]; 0 when empty
- count  output  CW  number of occupied entries, 0..DEPTH
- full  output  1  count == DEPTH (combinational from `count`)
- empty  output  1  count == 0 (combinational from `count`)
- overflow  output  1  one-cycle pulse: a push was refused
- underflow  output  1  one-cycle pulse: a pop was refused

## Operation
- Storage is mem[0..DEPTH-1]. The entry at index count-1 is the top. Memory is not reset and not cleared on pop.
- Reset (async) sets count=0, dout=0, dout_valid=0, overflow=0, underflow=0. It dominates everything.
- Per-edge priority: clr > push/pop decode. When clr=1: count←0, dout holds, dout_valid=0, overflow=0, underflow=0; push and pop are ignored.
- push=1, pop=0, not full: mem[count]←din, count←count+1.
- push=1, pop=0, full: no state change; overflow=1 for one cycle.
- push=0, pop=1, not empty: dout←mem[count-1], count←count-1, dout_valid=1.
- push=0, pop=1, empty: dout holds; underflow=1 for one cycle; dout_valid=0.
- push=1, pop=1, not empty (exchange): dout←mem[count-1], mem[count-1]←din, count unchanged, dout_valid=1. This applies when full as well; no overflow.
- push=1, pop=1, empty: the push is performed (count 0→1, mem[0]←din), underflow=1, dout holds, dout_valid=0.
- Neither push nor pop: state holds; dout_valid, overflow and underflow are 0.
- count never wraps: saturation is enforced by the refusal rules above. `count` arithmetic is CW bits wide, and the memory index uses count-1 truncated to $clog2(DEPTH) bits.

## Timing
- Single clock. dout, dout_valid, count, overflow and underflow are registers.
- Pop latency is 1 cycle: a pop sampled at edge N shows its data on `dout`, with dout_valid=1, after edge N.
- `top` reflects a push one edge after it: a push at edge N updates `top` after edge N. full, empty and top change in the same cycle as count.
- Back-to-back push or pop every cycle is supported at full rate; there are no stall cycles.
- Reset asserted mid-operation clears state immediately, independent of clk. Release is synchronous to the next edge, and the first push is accepted at the first edge with reset=0.
- Error pulses last exactly one cycle per refused request. Repeated refused requests on consecutive cycles hold the pulse high continuously.

## Test plan
- WIDTH=8, DEPTH=4, reset then push 0x11,0x22,0x33,0x44 → count=4, full=1, top=0x44. A fifth push of 0x55 → overflow=1 for one cycle, count=4, top=0x44.
- Pop ×4 from the state above → dout=0x44,0x33,0x22,0x11 on successive cycles with dout_valid=1 each cycle. Then empty=1 and top=0. A fifth pop → underflow=1, dout stays 0x11, dout_valid=0.
- Push 0xA0,0xA1, then push+pop with din=0xB0 → dout=0xA1, dout_valid=1, count=2, top=0xB0. Repeat while full (DEPTH=4) → no overflow, count=4.
- Push+pop with din=0x5A while empty → count=1, top=0x5A, underflow=1, dout_valid=0, dout unchanged.
- Push 3 entries, then clr=1 together with push=1 → count=0, empty=1, no overflow. The next push of 0x77 → top=0x77, count=1.
- Assert reset asynchronously between edges with count=3 and dout=0x22 → count=0, dout=0, all flags low before the next edge. Push on the first edge after release → count=1.

Source files
------------

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with status flags, combinational top-of-stack peek,
// error pulses, push+pop exchange and synchronous clear.
module lifo_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic [WIDTH-1:0] top_word;
  logic             full_int;
  logic             empty_int;

  // top_idx wraps when empty; every use of it is qualified by empty_int.
  assign top_idx   = AW'(count_reg - CW'(1));
  assign push_idx  = AW'(count_reg);
  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);
  assign top_word  = mem[top_idx];

  always_comb begin
    count_next      = count_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;
    overflow_next   = 1'b0;
    underflow_next  = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = push_idx;

    if (clr) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (full_int) begin
            overflow_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            count_next = count_reg + CW'(1);
          end
        end
        2'b01: begin
          if (empty_int) begin
            underflow_next = 1'b1;
          end else begin
            dout_next       = top_word;
            dout_valid_next = 1'b1;
            count_next      = count_reg - CW'(1);
          end
        end
        2'b11: begin
          // Exchange replaces the top in place, so it never overflows even when full.
          if (empty_int) begin
            wr_en          = 1'b1;
            count_next     = CW'(1);
            underflow_next = 1'b1;
          end else begin
            wr_en           = 1'b1;
            wr_idx          = top_idx;
            dout_next       = top_word;
            dout_valid_next = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
    end
  end

  // Storage is intentionally left out of reset; occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign count      = count_reg;
  assign full       = full_int;
  assign empty      = empty_int;
  assign top        = empty_int ? '0 : top_word;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule
